gait_spi_master: RTL

//  SPI initiator (mode 0, MSB first) that streams gait frames of 16-bit words from the FPGA to
//  the downstream servo/leg driver and captures the driver's reply words from MISO.
//  It is the initiator counterpart of the Arduino-facing SPI responder: gait_calculator output

---
 rtl/gait_spi_master.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/gait_spi_master.sv
// gait_spi_master: mode-0 SPI initiator streaming 16-bit gait words, MSB first.
// Define GAIT_SPI_CRC_EN to append and check a CRC-8 trailer byte per frame.
`timescale 1ns/1ps
module gait_spi_master #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_WORDS = 18,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  frame_len,
  input  logic [15:0] tx_word,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [15:0] rx_word,
  output logic        rx_valid,
  output logic        busy,
  output logic        done,
  output logic        crc_err,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_SHIFT, S_CRC, S_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [15:0] tmr;
  logic [15:0] tx_sh;
  logic [15:0] rx_sh;
  logic [4:0]  bit_cnt;
  logic [4:0]  words_left;
  logic [4:0]  len_clamp;
  logic [1:0]  miso_q;
  logic        miso_s;
  logic        div_end, in_bits, rise, fall;
  logic        word_end, setup_end, hold_end;
  logic        accept, last_word;

  assign miso_s    = miso_q[1];
  assign spi_mosi  = tx_sh[15];
  assign len_clamp = (frame_len > 5'(MAX_WORDS)) ?
                     5'(MAX_WORDS) : frame_len;

  // start is blocked while done is high so cs_n stays up a cycle
  assign accept    = (state == S_IDLE) && start &&
                     (frame_len != 5'd0) && !done;
  assign div_end   = (tmr == 16'(CLK_DIV - 1));
  assign in_bits   = (state == S_SHIFT) || (state == S_CRC);
  assign rise      = in_bits && div_end && !spi_clk;
  assign fall      = in_bits && div_end && spi_clk;
  assign word_end  = (state == S_SHIFT) && fall &&
                     (bit_cnt == 5'd15);
  assign setup_end = (state == S_SETUP) &&
                     (tmr == 16'(CS_SETUP - 1));
  assign hold_end  = (state == S_HOLD) &&
                     (tmr == 16'(CS_HOLD - 1));
  assign last_word = (words_left == 5'd1);

`ifdef GAIT_SPI_CRC_EN
  logic [7:0] crc_tx, crc_rx;
  logic       crc_bad, crc_end;

  assign crc_end = (state == S_CRC) && fall &&
                   (bit_cnt == 5'd7);

  function automatic logic [7:0] crc8_step(
    input logic [7:0] c,
    input logic       b
  );
    return {c[6:0], 1'b0} ^ ({8{c[7] ^ b}} & 8'h07);
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)    state_nxt = S_SETUP;
      S_SETUP: if (setup_end) state_nxt = S_LOAD;
      S_LOAD:  if (tx_valid)  state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (word_end) begin
          if (!last_word) state_nxt = S_LOAD;
`ifdef GAIT_SPI_CRC_EN
          else            state_nxt = S_CRC;
`else
          else            state_nxt = S_HOLD;
`endif
        end
      end
`ifdef GAIT_SPI_CRC_EN
      S_CRC:   if (crc_end)   state_nxt = S_HOLD;
`else
      S_CRC:                  state_nxt = S_IDLE;
`endif
      S_HOLD:  if (hold_end)  state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state == S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_cs_n   <= 1'b1;
      spi_clk    <= 1'b0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_word    <= '0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tmr        <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      miso_q     <= '0;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      miso_q   <= {miso_q[0], spi_miso};
      case (state)
        S_IDLE: begin
          if (accept) begin
            spi_cs_n   <= 1'b0;
            busy       <= 1'b1;
            tmr        <= '0;
            words_left <= len_clamp;
          end
        end
        S_SETUP: tmr <= setup_end ? '0 : tmr + 16'd1;
        S_LOAD: begin
          if (tx_valid) begin
            tx_sh   <= tx_word;
            tmr     <= '0;
            bit_cnt <= '0;
          end
        end
        S_SHIFT, S_CRC: begin
          tmr <= div_end ? '0 : tmr + 16'd1;
          if (rise) begin
            spi_clk <= 1'b1;
            rx_sh   <= {rx_sh[14:0], miso_s};
          end
          if (fall) begin
            spi_clk <= 1'b0;
            bit_cnt <= bit_cnt + 5'd1;
            tx_sh   <= {tx_sh[14:0], 1'b0};
          end
          if (word_end) begin
            rx_word    <= rx_sh;
            rx_valid   <= 1'b1;
            words_left <= words_left - 5'd1;
`ifdef GAIT_SPI_CRC_EN
            if (last_word) begin
              tx_sh   <= {crc_tx, 8'h00};
              bit_cnt <= '0;
            end
`endif
          end
        end
        S_HOLD: begin
          tmr <= tmr + 16'd1;
          if (hold_end) begin
            spi_cs_n <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GAIT_SPI_CRC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_tx  <= '0;
      crc_rx  <= '0;
      crc_bad <= 1'b0;
      crc_err <= 1'b0;
    end else begin
      if (accept) begin
        crc_tx  <= '0;
        crc_rx  <= '0;
        crc_bad <= 1'b0;
        crc_err <= 1'b0;
      end
      // both CRCs advance on the sampling edge, payload words only
      if ((state == S_SHIFT) && rise) begin
        crc_tx <= crc8_step(crc_tx, tx_sh[15]);
        crc_rx <= crc8_step(crc_rx, miso_s);
      end
      if (crc_end)  crc_bad <= (rx_sh[7:0] != crc_rx);
      if (hold_end) crc_err <= crc_bad;
    end
  end
`else
  assign crc_err = 1'b0;
`endif

endmodule
